// File: rtl/serial_parity_pkg.sv
// Shared definitions for the serial parity link (transmitter and receiver).
package serial_parity_pkg;

   // Frame position of the receiver: waiting for bit 0, collecting data, or expecting parity.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   // Initial accumulator value selecting the expected parity sense.
   localparam bit PARITY_EVEN = 1'b0;
   localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/xor_accumulator.sv
// One-bit running XOR register used to compute frame parity on both link ends.
// clr restarts the accumulation from INIT; when en is also set, the current
// in_bit is folded into the restarted value in the same cycle.
module xor_accumulator
   import serial_parity_pkg::*;
#(
   parameter bit INIT = PARITY_EVEN
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic in_bit,
   output logic acc
);

   // Accumulator register: restart from INIT on clr, XOR in in_bit on en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= INIT;
      end else if (en) begin
         acc <= (clr ? INIT : acc) ^ in_bit;
      end else if (clr) begin
         acc <= INIT;
      end
   end

endmodule

// File: rtl/serial_parity_receiver.sv
// Serial frame receiver: WIDTH data bits LSB first followed by one parity bit.
// Input qualification: a bit is consumed only on a cycle with in_valid=1; there
// is no back-pressure. in_first marks bit 0 of a frame and, if a frame is in
// progress, discards it (out_abort). out_valid/out_abort are single-cycle pulses
// issued one cycle after the bit that caused them; out_data/out_parity_err hold
// until the next completed frame.
module serial_parity_receiver
   import serial_parity_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_first,
   input  logic             in_bit,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_parity_err,
   output logic             out_abort
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state;
   state_t             state_n;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   shreg;
   logic               acc;

   // Per-cycle datapath controls decoded by the FSM.
   logic               start;   // in_bit is bit 0 of a new frame
   logic               shift;   // in_bit is a data bit 1..WIDTH-1
   logic               done;    // in_bit is the parity bit
   logic               abort;   // a partial frame is being discarded

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and datapath control decode; nothing moves without in_valid.
   always_comb begin
      state_n = state;
      start   = 1'b0;
      shift   = 1'b0;
      done    = 1'b0;
      abort   = 1'b0;
      if (in_valid) begin
         case (state)
            IDLE: begin
               if (in_first) begin
                  start   = 1'b1;
                  state_n = DATA;
               end
            end
            DATA: begin
               if (in_first) begin
                  abort   = 1'b1;
                  start   = 1'b1;
                  state_n = DATA;
               end else begin
                  shift = 1'b1;
                  if (cnt == CNT_W'(WIDTH - 1)) begin
                     state_n = PARITY;
                  end
               end
            end
            PARITY: begin
               if (in_first) begin
                  abort   = 1'b1;
                  start   = 1'b1;
                  state_n = DATA;
               end else begin
                  done    = 1'b1;
                  state_n = IDLE;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // Bit counter: number of data bits collected in the current frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= CNT_W'(1);
      end else if (shift) begin
         cnt <= cnt + CNT_W'(1);
      end else if (done) begin
         cnt <= '0;
      end
   end

   // Shift register: bits enter at the MSB so bit 0 lands at the LSB after WIDTH bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
      end else if (start) begin
         shreg <= {in_bit, {(WIDTH - 1){1'b0}}};
      end else if (shift) begin
         shreg <= {in_bit, shreg[WIDTH-1:1]};
      end
   end

   // Running parity over the data bits, seeded with the expected parity sense.
   xor_accumulator #(
      .INIT (PARITY_ODD)
   ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (start),
      .en     (start | shift),
      .in_bit (in_bit),
      .acc    (acc)
   );

   // Output registers: pulses for one cycle, word and error held until the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_abort      <= 1'b0;
         out_data       <= '0;
         out_parity_err <= 1'b0;
      end else begin
         out_valid <= done;
         out_abort <= abort;
         if (done) begin
            out_data       <= shreg;
            out_parity_err <= acc ^ in_bit;
         end
      end
   end

endmodule
